// File: rtl/lvt_wr_dispatch.sv
// lvt_wr_dispatch: in-order write-request queue feeding the two write ports of lvt_bram.
// Each cycle it accepts one request and issues up to two, and it offers a pending-address lookup.
// Optional build macro LVT_WR_COALESCE_EN: when the two oldest entries share an address,
// only the newer one is issued and both are retired in the same cycle.
module lvt_wr_dispatch #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic [ADDR_W-1:0]        wr0_addr,
  output logic [DATA_W-1:0]        wr0_data,
  output logic                     wr0_en,
  output logic [ADDR_W-1:0]        wr1_addr,
  output logic [DATA_W-1:0]        wr1_data,
  output logic                     wr1_en,
  input  logic [ADDR_W-1:0]        chk_addr,
  output logic                     chk_hit,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  nx_ptr;
  logic              push;
  logic [1:0]        pop_n;
  logic              same_addr;
  logic              issue0;
  logic              issue1;
  logic [ADDR_W-1:0] iss0_addr;
  logic [DATA_W-1:0] iss0_data;
  logic [ADDR_W-1:0] iss1_addr;
  logic [DATA_W-1:0] iss1_data;
  logic [PTR_W-1:0]  slot_ofs;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = rst & ~full;
  assign push      = in_valid & in_ready;
  assign nx_ptr    = rd_ptr + PTR_W'(1);
  assign same_addr = (q_addr[rd_ptr] == q_addr[nx_ptr]);

  // Decide what leaves the queue this cycle, looking only at the two oldest entries.
  always_comb begin
    pop_n     = 2'd0;
    issue0    = 1'b0;
    issue1    = 1'b0;
    iss0_addr = q_addr[rd_ptr];
    iss0_data = q_data[rd_ptr];
    iss1_addr = q_addr[nx_ptr];
    iss1_data = q_data[nx_ptr];
    if (drain_en && !empty) begin
      issue0 = 1'b1;
      if (count == CNT_W'(1)) begin
        pop_n = 2'd1;
      end else if (!same_addr) begin
        issue1 = 1'b1;
        pop_n  = 2'd2;
      end else begin
`ifdef LVT_WR_COALESCE_EN
        iss0_addr = q_addr[nx_ptr];
        iss0_data = q_data[nx_ptr];
        pop_n     = 2'd2;
`else
        pop_n     = 2'd1;
`endif
      end
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      count  <= count + CNT_W'(push) - CNT_W'(pop_n);
    end
  end

  // Queue storage needs no reset because only slots inside head..tail are ever read as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= in_addr;
      q_data[wr_ptr] <= in_data;
    end
  end

  // Registered write ports: enables reload every cycle, address/data hold while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr0_en   <= 1'b0;
      wr0_addr <= '0;
      wr0_data <= '0;
      wr1_en   <= 1'b0;
      wr1_addr <= '0;
      wr1_data <= '0;
    end else begin
      wr0_en <= issue0;
      wr1_en <= issue1;
      if (issue0) begin
        wr0_addr <= iss0_addr;
        wr0_data <= iss0_data;
      end
      if (issue1) begin
        wr1_addr <= iss1_addr;
        wr1_data <= iss1_data;
      end
    end
  end

  // Pending-write lookup over the occupied slots and the in-flight port registers.
  always_comb begin
    chk_hit  = 1'b0;
    slot_ofs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_ofs = PTR_W'(i) - rd_ptr;
      if (({1'b0, slot_ofs} < count) && (q_addr[i] == chk_addr)) chk_hit = 1'b1;
    end
    if (wr0_en && (wr0_addr == chk_addr)) chk_hit = 1'b1;
    if (wr1_en && (wr1_addr == chk_addr)) chk_hit = 1'b1;
  end

endmodule

// File: tb/tb_lvt_wr_dispatch.sv
// tb_lvt_wr_dispatch: directed bench for lvt_wr_dispatch with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations for each scenario.
// Honours LVT_WR_COALESCE_EN the same way as the design.
module tb_lvt_wr_dispatch;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        drain_en = 1'b0;
  logic [6:0]  wr0_addr;
  logic [31:0] wr0_data;
  logic        wr0_en;
  logic [6:0]  wr1_addr;
  logic [31:0] wr1_data;
  logic        wr1_en;
  logic [6:0]  chk_addr = '0;
  logic        chk_hit;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  int checks = 0;
  int errors = 0;

  req_t        model_q[$];
  logic        m_wr0_en = 1'b0;
  logic [6:0]  m_wr0_addr = '0;
  logic [31:0] m_wr0_data = '0;
  logic        m_wr1_en = 1'b0;
  logic [6:0]  m_wr1_addr = '0;
  logic [31:0] m_wr1_data = '0;

  logic [31:0] mem_obs [128];

  lvt_wr_dispatch #(.ADDR_W(7), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en),
    .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_en(wr0_en),
    .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_en(wr1_en),
    .chk_addr(chk_addr), .chk_hit(chk_hit),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Reference model: a plain FIFO of requests; each edge retires the oldest entries by the issue rules.
  always @(posedge clk or negedge rst) begin
    req_t h0;
    req_t h1;
    bit   do_push;
    if (!rst) begin
      model_q.delete();
      m_wr0_en = 1'b0; m_wr0_addr = '0; m_wr0_data = '0;
      m_wr1_en = 1'b0; m_wr1_addr = '0; m_wr1_data = '0;
    end else begin
      do_push  = in_valid && (model_q.size() < DEPTH);
      m_wr0_en = 1'b0;
      m_wr1_en = 1'b0;
      if (drain_en && model_q.size() > 0) begin
        h0 = model_q.pop_front();
        if (model_q.size() > 0 && model_q[0].addr != h0.addr) begin
          h1 = model_q.pop_front();
          m_wr0_en = 1'b1; m_wr0_addr = h0.addr; m_wr0_data = h0.data;
          m_wr1_en = 1'b1; m_wr1_addr = h1.addr; m_wr1_data = h1.data;
        end else if (model_q.size() > 0) begin
`ifdef LVT_WR_COALESCE_EN
          h1 = model_q.pop_front();
          m_wr0_en = 1'b1; m_wr0_addr = h1.addr; m_wr0_data = h1.data;
`else
          m_wr0_en = 1'b1; m_wr0_addr = h0.addr; m_wr0_data = h0.data;
`endif
        end else begin
          m_wr0_en = 1'b1; m_wr0_addr = h0.addr; m_wr0_data = h0.data;
        end
      end
      if (do_push) model_q.push_back('{addr: in_addr, data: in_data});
    end
  end

  // Single comparison helper; every failing comparison prints exactly one line.
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares every DUT output against the reference model.
  task automatic checkOutput();
    logic exp_hit;
    exp_hit = 1'b0;
    foreach (model_q[i]) if (model_q[i].addr == chk_addr) exp_hit = 1'b1;
    if (m_wr0_en && m_wr0_addr == chk_addr) exp_hit = 1'b1;
    if (m_wr1_en && m_wr1_addr == chk_addr) exp_hit = 1'b1;
    check("m_wr0_en",   wr0_en,   m_wr0_en);
    check("m_wr0_addr", wr0_addr, m_wr0_addr);
    check("m_wr0_data", wr0_data, m_wr0_data);
    check("m_wr1_en",   wr1_en,   m_wr1_en);
    check("m_wr1_addr", wr1_addr, m_wr1_addr);
    check("m_wr1_data", wr1_data, m_wr1_data);
    check("m_count",    count,    model_q.size());
    check("m_empty",    empty,    model_q.size() == 0);
    check("m_full",     full,     model_q.size() == DEPTH);
    check("m_in_ready", in_ready, rst && (model_q.size() < DEPTH));
    check("m_chk_hit",  chk_hit,  exp_hit);
  endtask

  // Per-cycle compare away from the active edge, and a record of what reached the memory ports.
  always @(negedge clk) begin
    checkOutput();
    if (wr0_en) mem_obs[wr0_addr] = wr0_data;
    if (wr1_en) mem_obs[wr1_addr] = wr1_data;
  end

  task automatic applyStimulus(input logic v, input logic [6:0] a, input logic [31:0] d, input logic dr);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    drain_en = dr;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushReq(input logic [6:0] a, input logic [31:0] d, input logic dr);
    applyStimulus(1'b1, a, d, dr);
    stepCycle();
    applyStimulus(1'b0, '0, '0, dr);
  endtask

  task automatic drainAll(input string name);
    applyStimulus(1'b0, '0, '0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (empty) break;
      stepCycle();
    end
    check(name, empty, 1);
    stepCycle();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem_obs[i] = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    @(posedge clk); #3 rst = 1'b1;
    stepCycle();
    check("rel_in_ready", in_ready, 1);

    // Reset mid-burst with three entries left and wr0 active.
    for (int i = 1; i <= 5; i++) pushReq(7'(i), 32'(200 + i), 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1);
    stepCycle();
    check("burst_count", count, 3);
    check("burst_wr0_en", wr0_en, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_wr0_en", wr0_en, 0);
    check("arst_wr1_en", wr1_en, 0);
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_in_ready", in_ready, 0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    @(posedge clk); #3 rst = 1'b1;
    stepCycle();
    check("arst_rel_ready", in_ready, 1);

    // Single write through an empty queue.
    pushReq(7'd10, 32'd5, 1'b1);
    stepCycle();
    check("single_wr0_en", wr0_en, 1);
    check("single_wr0_addr", wr0_addr, 10);
    check("single_wr0_data", wr0_data, 5);
    check("single_wr1_en", wr1_en, 0);
    check("single_count", count, 0);
    stepCycle();
    check("single_en_drop", wr0_en, 0);

    // Dual issue of two distinct addresses.
    pushReq(7'd20, 32'd10, 1'b0);
    pushReq(7'd30, 32'd15, 1'b0);
    check("dual_count2", count, 2);
    applyStimulus(1'b0, '0, '0, 1'b1);
    stepCycle();
    check("dual_wr0_addr", wr0_addr, 20);
    check("dual_wr0_data", wr0_data, 10);
    check("dual_wr1_addr", wr1_addr, 30);
    check("dual_wr1_data", wr1_data, 15);
    check("dual_both_en", {wr0_en, wr1_en}, 2'b11);
    check("dual_count0", count, 0);
    stepCycle();

    // Fill to full, hold the ninth request, then drain with wrap.
    for (int i = 0; i < 8; i++) pushReq(7'(i), 32'(i + 100), 1'b0);
    applyStimulus(1'b1, 7'd8, 32'd108, 1'b0);
    stepCycle();
    check("full_flag", full, 1);
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 8);
    applyStimulus(1'b1, 7'd8, 32'd108, 1'b1);
    stepCycle();
    check("wrap_p1_wr0", wr0_addr, 0);
    check("wrap_p1_wr1", wr1_addr, 1);
    check("wrap_p1_data", wr0_data, 100);
    check("wrap_p1_count", count, 6);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b1);
    check("wrap_p2_wr0", wr0_addr, 2);
    check("wrap_p2_wr1", wr1_addr, 3);
    check("wrap_p2_count", count, 5);
    stepCycle();
    stepCycle();
    check("wrap_p4_wr1", wr1_addr, 7);
    check("wrap_p4_count", count, 1);
    stepCycle();
    check("wrap_last_wr0", {wr0_addr, wr0_data}, {7'd8, 32'd108});
    check("wrap_last_wr1_en", wr1_en, 0);
    check("wrap_empty", empty, 1);
    stepCycle();

    // Same-address pair.
    pushReq(7'd50, 32'd25, 1'b0);
    pushReq(7'd50, 32'd30, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1);
    stepCycle();
`ifdef LVT_WR_COALESCE_EN
    check("same_wr0", {wr0_en, wr0_addr, wr0_data}, {1'b1, 7'd50, 32'd30});
    check("same_wr1_en", wr1_en, 0);
    check("same_count", count, 0);
`else
    check("same_wr0_a", {wr0_en, wr0_addr, wr0_data}, {1'b1, 7'd50, 32'd25});
    check("same_wr1_en", wr1_en, 0);
    check("same_count", count, 1);
    stepCycle();
    check("same_wr0_b", {wr0_en, wr0_addr, wr0_data}, {1'b1, 7'd50, 32'd30});
`endif
    drainAll("same_drain");

    // Pending-address lookup.
    pushReq(7'd70, 32'd1, 1'b0);
    pushReq(7'd80, 32'd2, 1'b0);
    chk_addr = 7'd70; #1;
    check("chk_hit70", chk_hit, 1);
    chk_addr = 7'd95; #1;
    check("chk_miss95", chk_hit, 0);
    chk_addr = 7'd80; #1;
    check("chk_hit80", chk_hit, 1);
    chk_addr = 7'd70;
    drainAll("chk_drain");
    check("chk_after_drain", chk_hit, 0);

    // Final contents as a lvt_bram downstream would have committed them.
    check("mem10", mem_obs[10], 5);
    check("mem20", mem_obs[20], 10);
    check("mem30", mem_obs[30], 15);
    check("mem8", mem_obs[8], 108);
    check("mem50", mem_obs[50], 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
